fifo_grace_sink: RTL
====================

FIFO_GRACE_SINK -- requirements
Module: fifo_grace_sink

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 32, the payload width in bits.
REQ-002 The module SHALL have parameter ADDR_WIDTH, default 5, the pointer width; DEPTH = 2**ADDR_WIDTH entries.
REQ-003 The module SHALL have parameter GRACE_PERIOD, default 2, the number of in-flight writes absorbed after if_full_n falls; legal range 0..DEPTH-1.
REQ-004 clk  input  1  the single clock; all logic is on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 if_full_n  output  1  registered; 1 = upstream may issue writes.
REQ-007 if_write_ce  input  1  write-side clock enable.
REQ-008 if_write  input  1  write strobe.
REQ-009 if_din  input  DATA_WIDTH  write data.
REQ-010 if_empty_n  output  1  registered; 1 = if_dout holds valid head data.
REQ-011 if_read_ce  input  1  read-side clock enable.
REQ-012 if_read  input  1  read strobe; pops the head entry.
REQ-013 if_dout  output  DATA_WIDTH  head-of-queue data, first-word-fall-through.

Function
REQ-014 The block SHALL be the sink of a chain of pipelined relay registers, absorbing writes that arrive up to GRACE_PERIOD cycles after if_full_n deasserts.
REQ-015 Write attempt = if_write & if_write_ce; read attempt = if_read & if_read_ce.
REQ-016 A read SHALL be accepted only when count > 0; a read attempt at count = 0 SHALL be ignored with no state change.
REQ-017 A write SHALL be accepted when count < DEPTH, or when count = DEPTH and a read is accepted in the same cycle.
REQ-018 A write attempt that is not accepted SHALL be silently dropped: no pointer, count or memory change.
REQ-019 Accepted write: mem[wr_ptr] <= if_din, wr_ptr increments modulo DEPTH.
REQ-020 Accepted read: rd_ptr increments modulo DEPTH.
REQ-021 count (ADDR_WIDTH+1 bits) SHALL update as +1 write only, -1 read only, unchanged for both or neither.
REQ-022 if_full_n SHALL be registered as (count_next < DEPTH - GRACE_PERIOD), i.e. it falls on the cycle after the accepted write that reaches the threshold.
REQ-023 if_empty_n SHALL be registered as (count_next != 0), giving write-to-visible latency of exactly 1 cycle.
REQ-024 if_dout SHALL equal mem[rd_ptr] whenever if_empty_n = 1, and SHALL change no earlier than the edge on which a read is accepted.
REQ-025 A write to an empty FIFO with a simultaneous read attempt SHALL NOT bypass; the read is ignored and the data appears next cycle.
REQ-026 Pointer wrap-around SHALL be seamless; ordering SHALL be strictly FIFO across wrap.
REQ-027 if_write_ce and if_read_ce SHALL gate their respective side only; a deasserted enable blocks that side with no effect on the other.

Reset
REQ-028 On reset = 1 at a clock edge: wr_ptr = 0, rd_ptr = 0, count = 0, if_empty_n = 0, if_full_n = 1; reset overrides any concurrent read or write.
REQ-029 Memory contents SHALL NOT be reset; if_dout is don't-care while if_empty_n = 0.
REQ-030 Reset mid-operation SHALL discard all stored entries; the first write after reset is the first word read.

Verification
REQ-031 Reset, then write 0x1,0x2,0x3 on consecutive cycles, no reads -> if_empty_n = 1 one cycle after the first write; if_dout = 0x1; three reads return 0x1,0x2,0x3; if_empty_n = 0 after the third read.
REQ-032 Defaults: write 30 words with no reads -> if_full_n = 0 on the cycle after the 30th write; 2 further writes are accepted (count = 32); a 33rd write is dropped; 32 reads return the first 32 words in order.
REQ-033 Full (count = 32), simultaneous read and write of 0xAA -> count stays 32, head advances; 0xAA is read as the 32nd subsequent word.
REQ-034 Empty, simultaneous write 0x5 and read -> read ignored; next cycle if_empty_n = 1 and if_dout = 0x5.
REQ-035 Stream 100 words with random if_read/if_write and if_*_ce toggling -> scoreboard matches in order across pointer wrap, and no write is lost while if_full_n was 1 up to GRACE_PERIOD cycles earlier.
REQ-036 Fill 10 words, assert reset for 1 cycle with if_write = 1 -> count = 0, if_empty_n = 0, if_full_n = 1; next written word 0x77 is the next word read.

Source files
------------

// File: rtl/fifo_grace_sink.sv
// fifo_grace_sink: first-word-fall-through FIFO that terminates a relay chain,
// deasserting if_full_n early enough to absorb GRACE_PERIOD in-flight writes.
module fifo_grace_sink #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 5,
    parameter int GRACE_PERIOD = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  if_full_n,
    input  logic                  if_write_ce,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_empty_n,
    input  logic                  if_read_ce,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   CNT_DEPTH = DEPTH;
    localparam logic [ADDR_WIDTH:0]   CNT_THRESH = DEPTH - GRACE_PERIOD;
    localparam logic [ADDR_WIDTH:0]   CNT_ONE = 1;
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  full_n_q, full_n_d, empty_n_q, empty_n_d;
    logic                  rd_acc, wr_acc;

    always_comb begin
        rd_acc    = if_read & if_read_ce & (count_q != '0);
        // a full FIFO still takes a write when a read frees the head slot this cycle
        wr_acc    = if_write & if_write_ce & ((count_q != CNT_DEPTH) | rd_acc);
        wr_ptr_d  = wr_acc ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d  = rd_acc ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        count_d   = count_q + (wr_acc ? CNT_ONE : '0) - (rd_acc ? CNT_ONE : '0);
        full_n_d  = count_d < CNT_THRESH;
        empty_n_d = count_d != '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            full_n_q  <= 1'b1;
            empty_n_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            full_n_q  <= full_n_d;
            empty_n_q <= empty_n_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc && !reset) mem[wr_ptr_q] <= if_din;
    end

    assign if_full_n  = full_n_q;
    assign if_empty_n = empty_n_q;
    assign if_dout    = mem[rd_ptr_q];
endmodule
